pool_window_buffer: RTL

Streaming 2x2 window generator that sits directly upstream of the combinational 2x2 max-pool stage. It accepts a feature map one pixel per beat in raster order and buffers one row. It emits non-overlapping stride-2 windows as four registered signed words (a, b, c, d) with a valid/ready handshake. One window is produced per completed 2x2 block, ready to be wired straight into the pooling stage's four inputs.

---
 rtl/pool_window_buffer.sv | 116 +++++++++++
 1 files changed

// File: rtl/pool_window_buffer.sv
// Streaming 2x2 stride-2 window generator feeding a 2x2 max-pool stage.
// Even rows are stored in a one-row line buffer; on odd rows the even-column
// pixel is held in prev_q and the odd-column pixel completes a window.
module pool_window_buffer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned IMG_WIDTH  = 28,
   parameter int unsigned IMG_HEIGHT = 28
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic signed [DATA_WIDTH-1:0] in_data_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   output logic signed [DATA_WIDTH-1:0] win_a_o,
   output logic signed [DATA_WIDTH-1:0] win_b_o,
   output logic signed [DATA_WIDTH-1:0] win_c_o,
   output logic signed [DATA_WIDTH-1:0] win_d_o,
   output logic                         win_valid_o,
   input  logic                         win_ready_i,
   output logic                         win_last_o
);

   localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int unsigned RowW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [ColW-1:0] ColMax = ColW'(IMG_WIDTH - 1);
   localparam logic [RowW-1:0] RowMax = RowW'(IMG_HEIGHT - 1);

   logic [ColW-1:0] col_q, col_d;
   logic [RowW-1:0] row_q, row_d;
   logic signed [DATA_WIDTH-1:0] prev_q, prev_d;
   logic signed [DATA_WIDTH-1:0] line_q [IMG_WIDTH];
   logic signed [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
   logic valid_q, valid_d;
   logic last_q, last_d;
   logic accept;
   logic line_we;

   // Uniform backpressure: a pixel is taken whenever the output slot is free or draining.
   assign in_ready_o = ~valid_q | win_ready_i;
   assign accept     = in_valid_i & in_ready_o;
   assign line_we    = accept & ~row_q[0];

   // Next-state: raster counters, odd-row holding register and window load.
   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      prev_d  = prev_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      d_d     = d_q;
      valid_d = valid_q & ~win_ready_i;
      last_d  = last_q & valid_d;
      if (accept) begin
         if (col_q == ColMax) begin
            col_d = '0;
            row_d = (row_q == RowMax) ? '0 : row_q + RowW'(1);
         end else begin
            col_d = col_q + ColW'(1);
         end
         if (row_q[0]) begin
            if (!col_q[0]) begin
               prev_d = in_data_i;
            end else begin
               // Odd column: col_q - 1 is the even partner already in the line buffer.
               a_d     = line_q[col_q - ColW'(1)];
               b_d     = line_q[col_q];
               c_d     = prev_q;
               d_d     = in_data_i;
               valid_d = 1'b1;
               last_d  = (row_q == RowMax) && (col_q == ColMax);
            end
         end
      end
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         col_q   <= '0;
         row_q   <= '0;
         prev_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         prev_q  <= prev_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   // Line buffer: even-row pixels, no reset needed since every entry is written before use.
   always_ff @(posedge clk_i) begin
      if (line_we) begin
         line_q[col_q] <= in_data_i;
      end
   end

   assign win_a_o     = a_q;
   assign win_b_o     = b_q;
   assign win_c_o     = c_q;
   assign win_d_o     = d_q;
   assign win_valid_o = valid_q;
   assign win_last_o  = last_q;

endmodule
